// File: rtl/bp_l15_miss_queue.sv
// In-order miss request FIFO feeding the BP->L1.5 transducer; holds the head stable until yumi
// and merges a back-to-back cached load to the same block into the tail entry.
module bp_l15_miss_queue #(
  parameter int unsigned els_p                = 4,
  parameter int unsigned paddr_width_p        = 40,
  parameter int unsigned block_offset_width_p = 6
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          miss_v_i,
  output logic                          miss_ready_o,
  input  logic                          uncached_i,
  input  logic                          store_i,
  input  logic [paddr_width_p-1:0]      addr_i,
  input  logic [2:0]                    lru_way_i,
  input  logic [63:0]                   store_data_i,
  input  logic [1:0]                    size_op_i,
  output logic                          coalesced_o,
  output logic                          miss_v_o,
  input  logic                          miss_yumi_i,
  output logic                          uncached_o,
  output logic                          store_o,
  output logic [paddr_width_p-1:0]      addr_o,
  output logic [2:0]                    lru_way_o,
  output logic [63:0]                   store_data_o,
  output logic [1:0]                    size_op_o,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic                          empty_o
);

  localparam int unsigned ptr_w = $clog2(els_p);
  localparam int unsigned cnt_w = $clog2(els_p + 1);

  typedef struct packed {
    logic                     uncached;
    logic                     store;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               lru_way;
    logic [63:0]              store_data;
    logic [1:0]               size_op;
  } entry_s;

  entry_s           mem [els_p];
  entry_s           in_entry;
  entry_s           head;
  logic [ptr_w-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [cnt_w-1:0] count_q;
  logic             coalesced_q;
  logic             full, has_entry, accept, coalesce, enq, deq, tail_cached_load, block_match;

  assign full      = (count_q == cnt_w'(els_p));
  assign has_entry = (count_q != '0);
  assign accept    = miss_v_i & ~full;
  assign deq       = miss_yumi_i & has_entry;

  // Tail is the most recently enqueued entry; it may be the head being yumi'd this cycle.
  assign tail_ptr         = wr_ptr_q - ptr_w'(1);
  assign tail_cached_load = has_entry & ~mem[tail_ptr].uncached & ~mem[tail_ptr].store;
  assign block_match      = (mem[tail_ptr].addr[paddr_width_p-1:block_offset_width_p]
                             == addr_i[paddr_width_p-1:block_offset_width_p]);
  assign coalesce         = accept & ~uncached_i & ~store_i & tail_cached_load & block_match;
  assign enq              = accept & ~coalesce;

  assign in_entry = '{uncached:   uncached_i,
                      store:      store_i,
                      addr:       addr_i,
                      lru_way:    lru_way_i,
                      store_data: store_data_i,
                      size_op:    size_op_i};

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      coalesced_q <= 1'b0;
    end else begin
      coalesced_q <= coalesce;
      if (enq) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + ptr_w'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + cnt_w'(1);
        2'b01:   count_q <= count_q - cnt_w'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head         = mem[rd_ptr_q];
  assign miss_v_o     = has_entry;
  assign miss_ready_o = ~full;
  assign empty_o      = ~has_entry;
  assign count_o      = count_q;
  assign coalesced_o  = coalesced_q;
  assign uncached_o   = head.uncached;
  assign store_o      = head.store;
  assign addr_o       = head.addr;
  assign lru_way_o    = head.lru_way;
  assign store_data_o = head.store_data;
  assign size_op_o    = head.size_op;

  // A yumi with nothing queued is a protocol error by the transducer.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                         miss_yumi_i |-> miss_v_o);

endmodule
